seq_rca_addsub: RTL and testbench

Parametrised, multi-cycle ripple-carry adder/subtractor. It processes WIDTH-bit operands CHUNK bits per clock, with the carry registered between chunks. It generalises the 4-bit combinational RCA to any width, adds subtract mode, carry-in, signed overflow and a start/busy/done handshake. It is used wherever wide arithmetic must trade latency for a short carry chain.

---
 rtl/seq_rca_addsub.sv | 145 ++++++++++++++
 tb/tb_seq_rca_addsub.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_rca_addsub.sv
// seq_rca_addsub: multi-cycle ripple-carry adder/subtractor.
// Adds WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a
// register so the combinational carry chain is only CHUNK bits long.
// Results (sum/cout/ovf/out) only change on the cycle an operation completes.
module seq_rca_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH:0]   out
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SELW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operands shift right one chunk per RUN cycle, so the active chunk is
    // always in the low CHUNK bits.
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]   chunkFull;
    logic             msbCarryIn;
    logic [SELW-1:0]  chunkBase;

    // State register; reset wins over everything and abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is honoured in IDLE and in the DONE cycle only.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy while chunks are being computed, done for the one
    // cycle in which the new result first appears.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Datapath next-state: load the effective operands on an accepted start,
    // add one chunk per RUN cycle, and publish the result on the last chunk.
    // Subtraction is a + ~b + ~cin, so cout becomes not-borrow naturally.
    always_comb begin
        opA_d     = opA_q;
        opB_d     = opB_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        partial_d = partial_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        chunkFull  = {1'b0, opA_q[CHUNK-1:0]} + {1'b0, opB_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
        msbCarryIn = opA_q[CHUNK-1] ^ opB_q[CHUNK-1] ^ chunkFull[CHUNK-1];
        chunkBase  = SELW'(idx_q * CHUNK);

        if (state_q == RUN) begin
            opA_d   = opA_q >> CHUNK;
            opB_d   = opB_q >> CHUNK;
            carry_d = chunkFull[CHUNK];
            idx_d   = idx_q + 1'b1;
            partial_d[chunkBase +: CHUNK] = chunkFull[CHUNK-1:0];
            if (idx_q == LAST_IDX) begin
                sum_d  = partial_d;
                cout_d = chunkFull[CHUNK];
                ovf_d  = msbCarryIn ^ chunkFull[CHUNK];
            end
        end else if (start) begin
            opA_d   = a;
            opB_d   = sub ? ~b : b;
            carry_d = sub ? ~cin : cin;
            idx_d   = '0;
        end
    end

    // Datapath registers; all cleared by reset so an aborted operation
    // leaves zeros on the result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            opA_q     <= '0;
            opB_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            partial_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            partial_q <= partial_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign out  = {cout_q, sum_q};

endmodule

// File: tb/tb_seq_rca_addsub.sv
// tb_seq_rca_addsub: self-checking bench for seq_rca_addsub.
// Three instances share operands: CHUNK=4 (main), CHUNK=16 (wide) and
// CHUNK=1 (serial). Expected results come from integer arithmetic on the
// operands, not from the adder structure.
module tb_seq_rca_addsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         startMain;
    logic         startAlt;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         busyV [3];
    logic         doneV [3];
    logic         coutV [3];
    logic         ovfV  [3];
    logic [W-1:0] sumV  [3];
    logic [W:0]   outV  [3];

    int           testCount = 0;
    int           failCount = 0;
    logic [W+1:0] lastMainResult;

    int           nchV  [3] = '{4, 1, 16};
    string        names [3] = '{"main", "wide", "serial"};

    seq_rca_addsub #(.WIDTH(W), .CHUNK(4)) dutMain (
        .clk(clk), .rst(rst), .start(startMain), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busyV[0]), .done(doneV[0]), .sum(sumV[0]),
        .cout(coutV[0]), .ovf(ovfV[0]), .out(outV[0])
    );

    seq_rca_addsub #(.WIDTH(W), .CHUNK(16)) dutWide (
        .clk(clk), .rst(rst), .start(startAlt), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busyV[1]), .done(doneV[1]), .sum(sumV[1]),
        .cout(coutV[1]), .ovf(ovfV[1]), .out(outV[1])
    );

    seq_rca_addsub #(.WIDTH(W), .CHUNK(1)) dutSerial (
        .clk(clk), .rst(rst), .start(startAlt), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busyV[2]), .done(doneV[2]), .sum(sumV[2]),
        .cout(coutV[2]), .ovf(ovfV[2]), .out(outV[2])
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from plain signed/unsigned integer math.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] aIn,
                                              input logic [W-1:0] bIn,
                                              input logic subIn,
                                              input logic cinIn);
        int ua, ub, ci, sa, sb, total, sres;
        logic co, ov;
        logic [W-1:0] s;
        ua = int'(aIn);
        ub = int'(bIn);
        ci = int'(cinIn);
        sa = int'($signed(aIn));
        sb = int'($signed(bIn));
        if (!subIn) begin
            total = ua + ub + ci;
            co    = (total > (1 << W) - 1);
            sres  = sa + sb + ci;
        end else begin
            total = ua - ub - ci;
            co    = (ua >= ub + ci);
            sres  = sa - sb - ci;
        end
        s  = total[W-1:0];
        ov = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
        return {ov, co, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                                 input logic subIn, input logic cinIn,
                                 input logic useAlt);
        a         = aIn;
        b         = bIn;
        sub       = subIn;
        cin       = cinIn;
        startMain = 1'b1;
        startAlt  = useAlt;
    endtask

    // One operation on all three instances: checks latency, single done
    // pulse, result, out consistency, and that main holds its old result
    // while busy even though the inputs are scrambled during RUN.
    task automatic runOp(input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                         input logic subIn, input logic cinIn, input string tag);
        logic [W+1:0] expected;
        logic [W+1:0] got [3];
        int busyCnt [3];
        int doneCnt [3];
        expected = refModel(aIn, bIn, subIn, cinIn);
        for (int k = 0; k < 3; k++) begin
            busyCnt[k] = 0;
            doneCnt[k] = 0;
            got[k]     = '0;
        end
        applyStimulus(aIn, bIn, subIn, cinIn, 1'b1);
        nextCycle();
        startMain = 1'b0;
        startAlt  = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
        for (int cyc = 0; cyc < 24; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (busyV[k]) busyCnt[k]++;
                if (doneV[k]) begin
                    doneCnt[k]++;
                    got[k] = {ovfV[k], coutV[k], sumV[k]};
                end
            end
            if (busyV[0])
                checkOutput({tag, " main hold"}, 64'({ovfV[0], outV[0]}), 64'(lastMainResult));
            nextCycle();
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput({tag, " ", names[k], " busyCycles"}, 64'(busyCnt[k]), 64'(nchV[k]));
            checkOutput({tag, " ", names[k], " donePulses"}, 64'(doneCnt[k]), 64'd1);
            checkOutput({tag, " ", names[k], " result"}, 64'(got[k]), 64'(expected));
            checkOutput({tag, " ", names[k], " out"}, 64'(outV[k]), 64'(expected[W:0]));
        end
        lastMainResult = expected;
    endtask

    // Main test sequence.
    initial begin
        logic [W+1:0] exp1, exp2, got1, got2;
        int busyCnt, doneCnt, firstDone, secondDone;

        rst = 1'b1; startMain = 1'b0; startAlt = 1'b0;
        sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        lastMainResult = '0;
        nextCycle();
        nextCycle();
        checkOutput("reset busy", 64'(busyV[0]), 64'd0);
        checkOutput("reset done", 64'(doneV[0]), 64'd0);
        checkOutput("reset sum",  64'(sumV[0]),  64'd0);
        checkOutput("reset cout", 64'(coutV[0]), 64'd0);
        checkOutput("reset ovf",  64'(ovfV[0]),  64'd0);
        checkOutput("reset out",  64'(outV[0]),  64'd0);
        checkOutput("reset serial out", 64'(outV[2]), 64'd0);
        rst = 1'b0;
        nextCycle();

        runOp(16'd6,      16'd4,      1'b0, 1'b0, "add 6+4");
        runOp(16'd14,     16'd10,     1'b0, 1'b1, "add 14+10+1");
        runOp(16'hFFFF,   16'h0001,   1'b0, 1'b0, "add ripple");
        runOp(16'h7FFF,   16'h0001,   1'b0, 1'b0, "add ovf");
        runOp(16'd5,      16'd7,      1'b1, 1'b0, "sub 5-7");
        runOp(16'd9,      16'd9,      1'b1, 1'b0, "sub 9-9");
        runOp(16'h8000,   16'h0001,   1'b1, 1'b0, "sub ovf");
        runOp(16'd9,      16'd4,      1'b1, 1'b1, "sub 9-4-1");
        runOp(16'h0000,   16'hFFFF,   1'b1, 1'b1, "sub 0-max-1");
        runOp(16'hFFFF,   16'hFFFF,   1'b0, 1'b1, "add max+max+1");

        for (int i = 0; i < 20; i++)
            runOp(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random");

        // start during busy is ignored and not queued
        exp1 = refModel(16'd1234, 16'd4321, 1'b0, 1'b0);
        got1 = '0; busyCnt = 0; doneCnt = 0;
        applyStimulus(16'd1234, 16'd4321, 1'b0, 1'b0, 1'b0);
        nextCycle();
        startMain = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc == 1) applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b0);
            if (cyc == 2) startMain = 1'b0;
            if (busyV[0]) busyCnt++;
            if (doneV[0]) begin
                doneCnt++;
                got1 = {ovfV[0], coutV[0], sumV[0]};
            end
            nextCycle();
        end
        checkOutput("ignored start busyCycles", 64'(busyCnt), 64'd4);
        checkOutput("ignored start donePulses", 64'(doneCnt), 64'd1);
        checkOutput("ignored start result", 64'(got1), 64'(exp1));
        lastMainResult = exp1;

        // start in the done cycle chains a second operation
        exp1 = refModel(16'h1111, 16'h2222, 1'b0, 1'b1);
        exp2 = refModel(16'h0100, 16'h0200, 1'b1, 1'b0);
        got1 = '0; got2 = '0; busyCnt = 0; firstDone = -1; secondDone = -1;
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0);
        nextCycle();
        startMain = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (startMain && firstDone >= 0) startMain = 1'b0;
            if (busyV[0]) busyCnt++;
            if (doneV[0]) begin
                if (firstDone < 0) begin
                    firstDone = cyc;
                    got1 = {ovfV[0], coutV[0], sumV[0]};
                    applyStimulus(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0);
                end else if (secondDone < 0) begin
                    secondDone = cyc;
                    got2 = {ovfV[0], coutV[0], sumV[0]};
                end
            end
            nextCycle();
        end
        checkOutput("b2b first result", 64'(got1), 64'(exp1));
        checkOutput("b2b second result", 64'(got2), 64'(exp2));
        checkOutput("b2b spacing", 64'(secondDone - firstDone), 64'd5);
        checkOutput("b2b busyCycles", 64'(busyCnt), 64'd8);
        lastMainResult = exp2;

        // reset in the 2nd busy cycle aborts without a done pulse
        applyStimulus(16'h4242, 16'h1313, 1'b0, 1'b0, 1'b0);
        nextCycle();
        startMain = 1'b0;
        nextCycle();
        rst = 1'b1;
        nextCycle();
        checkOutput("abort busy", 64'(busyV[0]), 64'd0);
        checkOutput("abort done", 64'(doneV[0]), 64'd0);
        checkOutput("abort out",  64'(outV[0]),  64'd0);
        checkOutput("abort ovf",  64'(ovfV[0]),  64'd0);
        rst = 1'b0;
        doneCnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (doneV[0]) doneCnt++;
            nextCycle();
        end
        checkOutput("abort no done", 64'(doneCnt), 64'd0);
        lastMainResult = '0;

        runOp(16'd6, 16'd4, 1'b0, 1'b0, "post-abort add");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
